// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller.
// Combines stall requests from ID, EX and MEM into per-stage hold enables,
// inserts bubbles on taken branches, and sequences trap entry / mret return
// through a short drain so older instructions retire before the redirect.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  input  logic        cnt_clr_i,
  output logic [4:0]  stalled_o,
  output logic [2:0]  flush_o,
  output logic        pc_set_o,
  output logic [31:0] pc_addr_o,
  output logic        trap_ack_o,
  output logic [15:0] stall_cnt_o
);

  // Hold-enable patterns: each stall source freezes its own stage and
  // everything upstream of it.
  localparam logic [4:0] HOLD_NONE = 5'b00000;
  localparam logic [4:0] HOLD_ID   = 5'b00011;
  localparam logic [4:0] HOLD_EX   = 5'b00111;
  localparam logic [4:0] HOLD_MEM  = 5'b01111;

  // Bubble patterns: a branch squashes the two younger stages, a trap
  // squashes everything still in flight ahead of MEM/WB.
  localparam logic [2:0] FLUSH_NONE   = 3'b000;
  localparam logic [2:0] FLUSH_BRANCH = 3'b011;
  localparam logic [2:0] FLUSH_TRAP   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ENTER = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] target;
  logic [15:0] stall_cnt;

  logic [4:0]  stalled;
  logic [2:0]  flush;
  logic        pc_set;
  logic [31:0] pc_addr;
  logic        trap_ack;
  logic        redirect_req;
  logic        branch_ok;

  // Saturating increment for the stall counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // While a trap/mret is being accepted or drained, EX is held so the
  // faulting context stays put; MEM additionally holds on a bus wait.
  function automatic logic [4:0] drain_hold(input logic mem_wait);
    drain_hold = mem_wait ? HOLD_MEM : HOLD_EX;
  endfunction

  // Plain stall priority: the deepest requesting stage decides the pattern.
  function automatic logic [4:0] stall_prio(input logic id_req,
                                            input logic ex_req,
                                            input logic mem_req);
    if (mem_req) begin
      stall_prio = HOLD_MEM;
    end else if (ex_req) begin
      stall_prio = HOLD_EX;
    end else if (id_req) begin
      stall_prio = HOLD_ID;
    end else begin
      stall_prio = HOLD_NONE;
    end
  endfunction

  assign redirect_req = trap_req_i | mret_i;
  // A branch is only acted on when EX itself is free to move; otherwise EX
  // keeps presenting it and it is taken later.
  assign branch_ok    = branch_flag_i & ~stallreq_ex & ~stallreq_mem;

  // Output decode from current state and live requests; reset forces all quiet.
  always_comb begin
    stalled  = HOLD_NONE;
    flush    = FLUSH_NONE;
    pc_set   = 1'b0;
    pc_addr  = 32'h0;
    trap_ack = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_req) begin
          stalled = drain_hold(stallreq_mem);
        end else if (branch_ok) begin
          pc_set  = 1'b1;
          pc_addr = branch_addr_i;
          flush   = FLUSH_BRANCH;
        end else begin
          stalled = stall_prio(stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      DRAIN: begin
        stalled = drain_hold(stallreq_mem);
      end
      ENTER: begin
        pc_set   = 1'b1;
        pc_addr  = target;
        flush    = FLUSH_TRAP;
        trap_ack = 1'b1;
      end
      default: begin
        stalled = HOLD_NONE;
      end
    endcase
    if (rst) begin
      stalled  = HOLD_NONE;
      flush    = FLUSH_NONE;
      pc_set   = 1'b0;
      pc_addr  = 32'h0;
      trap_ack = 1'b0;
    end
  end

  assign stalled_o   = stalled;
  assign flush_o     = flush;
  assign pc_set_o    = pc_set;
  assign pc_addr_o   = pc_addr;
  assign trap_ack_o  = trap_ack;
  assign stall_cnt_o = rst ? 16'h0 : stall_cnt;

  // Trap/mret sequencer: latch the redirect target, wait out bus waits, redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      target <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req_i) begin
            target <= trap_vec_i;
            state  <= DRAIN;
          end else if (mret_i) begin
            target <= mepc_i;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stallreq_mem) begin
            state <= ENTER;
          end
        end
        ENTER: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall-cycle counter: clear has priority, otherwise count any held cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0;
    end else if (cnt_clr_i) begin
      stall_cnt <= 16'h0;
    end else if (stalled != HOLD_NONE) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic        mret_i;
  logic [31:0] mepc_i;
  logic        cnt_clr_i;
  logic [4:0]  stalled_o;
  logic [2:0]  flush_o;
  logic        pc_set_o;
  logic [31:0] pc_addr_o;
  logic        trap_ack_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: a redirect sequence is either waiting for the
  // bus to go quiet, or due to fire this cycle.
  bit          m_waiting;
  bit          m_fire;
  logic [31:0] m_dest;
  int          m_cnt;

  // Snapshot of the DUT outputs from the most recent cycle.
  logic [4:0]  o_stalled;
  logic [2:0]  o_flush;
  logic        o_pc_set;
  logic [31:0] o_pc_addr;
  logic        o_ack;
  logic [15:0] o_cnt;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i),
    .trap_req_i   (trap_req_i),
    .trap_vec_i   (trap_vec_i),
    .mret_i       (mret_i),
    .mepc_i       (mepc_i),
    .cnt_clr_i    (cnt_clr_i),
    .stalled_o    (stalled_o),
    .flush_o      (flush_o),
    .pc_set_o     (pc_set_o),
    .pc_addr_o    (pc_addr_o),
    .trap_ack_o   (trap_ack_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    stallreq_id   = 1'b0;
    stallreq_ex   = 1'b0;
    stallreq_mem  = 1'b0;
    branch_flag_i = 1'b0;
    branch_addr_i = 32'h0;
    trap_req_i    = 1'b0;
    trap_vec_i    = 32'h0;
    mret_i        = 1'b0;
    mepc_i        = 32'h0;
    cnt_clr_i     = 1'b0;
  endtask

  // One clock: inputs are already applied; compare mid-cycle, then advance.
  task automatic cycle();
    logic [4:0]  e_stalled;
    logic [2:0]  e_flush;
    logic        e_pc_set;
    logic [31:0] e_pc_addr;
    logic        e_ack;
    logic [15:0] e_cnt;
    @(negedge clk);
    e_stalled = 5'h0;
    e_flush   = 3'h0;
    e_pc_set  = 1'b0;
    e_pc_addr = 32'h0;
    e_ack     = 1'b0;
    e_cnt     = rst ? 16'h0 : 16'(m_cnt);
    if (!rst) begin
      if (m_fire) begin
        e_pc_set  = 1'b1;
        e_pc_addr = m_dest;
        e_flush   = 3'b111;
        e_ack     = 1'b1;
      end else if (m_waiting || trap_req_i || mret_i) begin
        e_stalled = stallreq_mem ? 5'b01111 : 5'b00111;
      end else if (branch_flag_i && !stallreq_ex && !stallreq_mem) begin
        e_pc_set  = 1'b1;
        e_pc_addr = branch_addr_i;
        e_flush   = 3'b011;
      end else if (stallreq_mem) e_stalled = 5'b01111;
      else if (stallreq_ex)      e_stalled = 5'b00111;
      else if (stallreq_id)      e_stalled = 5'b00011;
    end
    o_stalled = stalled_o;
    o_flush   = flush_o;
    o_pc_set  = pc_set_o;
    o_pc_addr = pc_addr_o;
    o_ack     = trap_ack_o;
    o_cnt     = stall_cnt_o;
    check("stalled", 32'(o_stalled), 32'(e_stalled));
    check("flush",   32'(o_flush),   32'(e_flush));
    check("pc_set",  32'(o_pc_set),  32'(e_pc_set));
    check("pc_addr", o_pc_addr,      e_pc_addr);
    check("ack",     32'(o_ack),     32'(e_ack));
    check("cnt",     32'(o_cnt),     32'(e_cnt));
    // advance the model to the next cycle
    if (rst) begin
      m_waiting = 1'b0;
      m_fire    = 1'b0;
      m_dest    = 32'h0;
      m_cnt     = 0;
    end else begin
      if (m_fire) begin
        m_fire = 1'b0;
      end else if (m_waiting) begin
        if (!stallreq_mem) begin
          m_waiting = 1'b0;
          m_fire    = 1'b1;
        end
      end else if (trap_req_i || mret_i) begin
        m_dest    = trap_req_i ? trap_vec_i : mepc_i;
        m_waiting = 1'b1;
      end
      if (cnt_clr_i) m_cnt = 0;
      else if (e_stalled != 5'h0 && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_waiting = 1'b0;
    m_fire    = 1'b0;
    m_dest    = 32'h0;
    m_cnt     = 0;
    quiet_inputs();

    // Reset with busy inputs: outputs must be forced quiet
    rst = 1'b1;
    stallreq_mem = 1'b1; trap_req_i = 1'b1; branch_flag_i = 1'b1;
    cycle();
    check("rst_stalled", 32'(o_stalled), 32'h0);
    check("rst_pc_set",  32'(o_pc_set),  32'h0);
    quiet_inputs();
    cycle();
    rst = 1'b0;
    cycle();
    check("idle_cnt", 32'(o_cnt), 32'h0);

    // Stall priority
    stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    cycle(); check("prio_mem", 32'(o_stalled), 32'h0F);
    stallreq_mem = 1'b0;
    cycle(); check("prio_ex",  32'(o_stalled), 32'h07);
    stallreq_ex = 1'b0;
    cycle(); check("prio_id",  32'(o_stalled), 32'h03);

    // Branch overrides ID stall, is ignored under EX stall
    branch_flag_i = 1'b1; branch_addr_i = 32'h0000_0100;
    cycle();
    check("br_pc_set",  32'(o_pc_set),  32'h1);
    check("br_addr",    o_pc_addr,      32'h100);
    check("br_flush",   32'(o_flush),   32'h3);
    check("br_stalled", 32'(o_stalled), 32'h0);
    stallreq_ex = 1'b1;
    cycle();
    check("brx_pc_set",  32'(o_pc_set),  32'h0);
    check("brx_stalled", 32'(o_stalled), 32'h07);
    quiet_inputs();
    cycle();

    // Trap without memory wait: redirect two cycles after request
    trap_req_i = 1'b1; trap_vec_i = 32'h8000_0000;
    cycle(); check("t_n_stalled", 32'(o_stalled), 32'h07);
    quiet_inputs();
    cycle(); check("t_n1_pc_set", 32'(o_pc_set), 32'h0);
    cycle();
    check("t_n2_pc_set", 32'(o_pc_set), 32'h1);
    check("t_n2_addr",   o_pc_addr,     32'h8000_0000);
    check("t_n2_flush",  32'(o_flush),  32'h7);
    check("t_n2_ack",    32'(o_ack),    32'h1);
    cycle();
    check("t_n3_pc_set", 32'(o_pc_set), 32'h0);
    check("t_n3_ack",    32'(o_ack),    32'h0);
    check("t_n3_flush",  32'(o_flush),  32'h0);

    // Trap with three memory-wait cycles and a simultaneous mret
    trap_req_i = 1'b1; trap_vec_i = 32'h8000_0040;
    mret_i = 1'b1; mepc_i = 32'h0000_1234; stallreq_mem = 1'b1;
    cycle(); check("tm_n_stalled", 32'(o_stalled), 32'h0F);
    trap_req_i = 1'b0;
    cycle(); check("tm_n1_stalled", 32'(o_stalled), 32'h0F);
    cycle(); check("tm_n2_stalled", 32'(o_stalled), 32'h0F);
    stallreq_mem = 1'b0;
    cycle();
    check("tm_n3_stalled", 32'(o_stalled), 32'h07);
    check("tm_n3_pc_set",  32'(o_pc_set),  32'h0);
    cycle();
    check("tm_n4_pc_set", 32'(o_pc_set), 32'h1);
    check("tm_n4_addr",   o_pc_addr,     32'h8000_0040);
    check("tm_n4_ack",    32'(o_ack),    32'h1);
    quiet_inputs();
    cycle();

    // Reset while draining abandons the sequence
    trap_req_i = 1'b1; trap_vec_i = 32'h0000_0200;
    cycle();
    trap_req_i = 1'b0; rst = 1'b1;
    cycle();
    check("rd_stalled", 32'(o_stalled), 32'h0);
    check("rd_ack",     32'(o_ack),     32'h0);
    rst = 1'b0;
    cycle();
    check("rd_after_ack",    32'(o_ack),    32'h0);
    check("rd_after_pc_set", 32'(o_pc_set), 32'h0);
    check("rd_after_cnt",    32'(o_cnt),    32'h0);
    cycle();
    check("rd_after2_ack", 32'(o_ack), 32'h0);

    // Counter saturation and clear
    stallreq_id = 1'b1;
    repeat (70000) cycle();
    cycle();
    check("cnt_sat", 32'(o_cnt), 32'hFFFF);
    cnt_clr_i = 1'b1;
    cycle();
    cnt_clr_i = 1'b0;
    cycle();
    check("cnt_clr", 32'(o_cnt), 32'h0);
    quiet_inputs();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      stallreq_id   = ($urandom_range(0, 3) == 0);
      stallreq_ex   = ($urandom_range(0, 3) == 0);
      stallreq_mem  = ($urandom_range(0, 3) == 0);
      branch_flag_i = ($urandom_range(0, 3) == 0);
      branch_addr_i = $urandom;
      trap_req_i    = ($urandom_range(0, 15) == 0);
      trap_vec_i    = $urandom;
      mret_i        = ($urandom_range(0, 15) == 0);
      mepc_i        = $urandom;
      cnt_clr_i     = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
